// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains fifo_sram into a valid/ready stream, tracking occupancy from the write strobe
module fifo_rd_stream #(
  parameter int DW     = 16,
  parameter int DEPTH  = 32,
  parameter int CW     = 6,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fifo_wr,
  output logic          fifo_rd,
  input  logic [DW-1:0] fifo_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);
  logic [RD_LAT-1:0] pipe, pipe_nx;
  logic [DW-1:0]     b0, b1;
  logic [1:0]        used, used_nx, tail;
  logic [CW-1:0]     count_nx;
  logic              wr_ok, push, pop, rd_nx;
  assign m_valid = |used;
  assign m_data  = b0;
  // next occupancy and read-issue decision; the two credits cover buffered plus in-flight words
  always_comb begin
    wr_ok    = fifo_wr & ~full;
    count_nx = count + CW'(wr_ok) - CW'(fifo_rd);
    push     = pipe[RD_LAT-1];
    pop      = m_valid & m_ready;
    used_nx  = used + 2'(push) - 2'(pop);
    tail     = used - 2'(pop);
    pipe_nx  = RD_LAT'({pipe, fifo_rd});
    rd_nx    = (count_nx != '0) && (32'(used_nx) + $countones(pipe_nx) < 2);
  end
  // occupancy, flags, read strobe and in-flight tag pipe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      fifo_rd  <= 1'b0;
      pipe     <= '0;
    end else begin
      count    <= count_nx;
      full     <= count_nx == CW'(DEPTH);
      empty    <= count_nx == '0;
      overflow <= overflow | (fifo_wr & full);
      fifo_rd  <= rd_nx;
      pipe     <= pipe_nx;
    end
  end
  // two-entry output buffer: pop shifts the tail forward, push lands at the post-pop tail
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      used <= '0;
      b0   <= '0;
      b1   <= '0;
    end else begin
      used <= used_nx;
      b0   <= (push && tail == 2'd0) ? fifo_dout : pop ? b1 : b0;
      b1   <= (push && tail == 2'd1) ? fifo_dout : b1;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of fifo_rd_stream against a behavioural fifo_sram and a word scoreboard
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  localparam int DW = 16, DEPTH = 32, CW = 6;
  logic clk = 1'b0, rstn = 1'b0, fifo_wr = 1'b0, m_ready = 1'b0;
  logic fifo_rd, m_valid, full, empty, overflow;
  logic [DW-1:0] fifo_dout, m_data, din = '0;
  logic [CW-1:0] count;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int wp, rp, mocc, n_cmp = 0, n_err = 0, n_rd = 0, n_pop = 0, base;

  fifo_rd_stream #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .RD_LAT(1)) dut (
    .clk(clk), .rstn(rstn), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_dout(fifo_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .full(full), .empty(empty), .overflow(overflow));

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // behavioural SRAM with one-cycle read latency; words it accepts enter the scoreboard
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= 0; rp <= 0; mocc <= 0; fifo_dout <= '0;
    end else begin
      if (fifo_wr && mocc != DEPTH) begin
        mem[wp] <= din; wp <= (wp + 1) % DEPTH; exp_q.push_back(din);
      end
      if (fifo_rd) begin
        fifo_dout <= mem[rp]; rp <= (rp + 1) % DEPTH;
      end
      mocc <= mocc + ((fifo_wr && mocc != DEPTH) ? 1 : 0) - (fifo_rd ? 1 : 0);
    end
  end

  // sample just before each rising edge: count read pulses and check every accepted word
  always begin
    @(negedge clk); #40;
    if (rstn) begin
      if (fifo_rd) n_rd++;
      if (m_valid && m_ready) begin
        n_pop++;
        if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 1);
        else chk("data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wr_word(input logic [DW-1:0] d, input bit tog);
    fifo_wr = 1'b1; din = d;
    if (tog) m_ready = ~m_ready;
    @(negedge clk);
    fifo_wr = 1'b0;
  endtask

  task automatic drain(input string tag, input bit tog);
    int k;
    for (k = 0; k < 400 && (exp_q.size() != 0 || m_valid); k++) begin
      m_ready = tog ? ~m_ready : 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #400;
    chk("rst_rd", 32'(fifo_rd), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ovf", 32'(overflow), 0);
    #10 rstn = 1'b1;
    @(negedge clk);
    // two words with an always-ready consumer
    m_ready = 1'b1; n_rd = 0; base = n_pop;
    wr_word(16'haa55, 0);
    wr_word(16'hff00, 0);
    repeat (6) @(negedge clk);
    chk("t2_rd_pulses", n_rd, 2);
    chk("t2_pops", n_pop - base, 2);
    chk("t2_count", 32'(count), 0);
    chk("t2_empty", 32'(empty), 1);
    // stalled consumer: only the two buffer credits are read out
    m_ready = 1'b0; n_rd = 0; base = n_pop;
    for (int i = 0; i < 32; i++) wr_word(16'(i), 0);
    repeat (4) @(negedge clk);
    chk("t3_rd_pulses", n_rd, 2);
    chk("t3_count", 32'(count), 30);
    chk("t3_full", 32'(full), 0);
    chk("t3_valid", 32'(m_valid), 1);
    chk("t3_head", 32'(m_data), 0);
    drain("t3_drain", 0);
    chk("t3_pops", n_pop - base, 32);
    chk("t3_count_end", 32'(count), 0);
    // overfill: 2 words reach the buffer early, then 32 fill the SRAM, the last 6 are dropped
    base = n_pop;
    for (int i = 0; i < 40; i++) wr_word(16'(100 + i), 0);
    repeat (3) @(negedge clk);
    chk("t4_count", 32'(count), 32);
    chk("t4_full", 32'(full), 1);
    chk("t4_ovf", 32'(overflow), 1);
    drain("t4_drain", 0);
    chk("t4_pops", n_pop - base, 34);
    chk("t4_empty", 32'(empty), 1);
    chk("t4_ovf_sticky", 32'(overflow), 1);
    // simultaneous write and read at count 5
    for (int i = 0; i < 7; i++) wr_word(16'(200 + i), 0);
    repeat (3) @(negedge clk);
    chk("t5_count_pre", 32'(count), 5);
    m_ready = 1'b1;
    begin
      int k;
      for (k = 0; k < 10 && !fifo_rd; k++) @(negedge clk);
      chk("t5_rd_seen", 32'(fifo_rd), 1);
    end
    m_ready = 1'b0;
    chk("t5_count_rd", 32'(count), 5);
    wr_word(16'd207, 0);
    chk("t5_count_both", 32'(count), 5);
    for (int i = 0; i < 10; i++) wr_word(16'(208 + i), 1);
    drain("t5_drain", 1);
    chk("t5_count_end", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    // reset with a word buffered and a word in flight
    wr_word(16'h0030, 0);
    wr_word(16'h0031, 0);
    wr_word(16'h0032, 0);
    chk("t6_valid_pre", 32'(m_valid), 1);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid_rst", 32'(m_valid), 0);
    chk("t6_count_rst", 32'(count), 0);
    chk("t6_empty_rst", 32'(empty), 1);
    chk("t6_rd_rst", 32'(fifo_rd), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_ovf_clr", 32'(overflow), 0);
    base = n_pop;
    m_ready = 1'b1;
    wr_word(16'h1234, 0);
    wr_word(16'h5678, 0);
    drain("t6_drain", 0);
    chk("t6_pops", n_pop - base, 2);
    chk("t6_count_end", 32'(count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
